fround_pipe: RTL and testbench
==============================

FROUND_PIPE -- requirements
Module: fround_pipe

Interface
REQ-001 Parameter N_INT, default 32, width of the input significand; its MSB is the implied 1.
REQ-002 Parameter N_EXP, default 8, exponent width.
REQ-003 Parameter N_SIG, default 23, stored fraction width; N_INT SHALL be at least N_SIG+3.
REQ-004 clk_i  in  1  sole clock; all state is rising-edge.
REQ-005 rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 in_valid_i  in  1  input beat valid.
REQ-007 in_ready_o  out  1  input beat accepted when valid and ready are both high.
REQ-008 sign_i  in  1, sig_i  in  N_INT, exp_i  in  N_EXP: unrounded operand; exp_i is biased.
REQ-009 rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 111 DYN.
REQ-010 frm_i  in  3  dynamic mode, sampled with the beat; used only when rm_i=111.
REQ-011 out_valid_o  out  1, out_ready_i  in  1: output handshake.
REQ-012 sign_o  out  1, sig_o  out  N_SIG, exp_o  out  N_EXP: rounded result.
REQ-013 nx_o  out  1 inexact; of_o  out  1 overflow; rm_err_o  out  1 reserved mode.

Function
REQ-014 Effective mode SHALL be frm_i when rm_i=111, otherwise rm_i; 101 and 110 are reserved.
REQ-015 Round bits SHALL be sig_i[N_INT-N_SIG-2:0]: guard = MSB of that field; sticky = OR of the rest; lsb = sig_i[N_INT-N_SIG-1].
REQ-016 Increment decision: RNE = guard & (sticky | lsb); RTZ = 0; RDN = sign & |round; RUP = ~sign & |round; RMM = guard.
REQ-017 A reserved effective mode SHALL truncate and set rm_err_o for that beat.
REQ-018 Carry out of fraction+increment SHALL give sig_o = 0 and exp_o = exp_i+1.
REQ-019 nx_o SHALL equal |round, or 1 on overflow.
REQ-020 Overflow occurs when exp_i is all ones or the rounded exponent reaches all ones; of_o=1 and nx_o=1.
REQ-021 Overflow result: RNE/RMM give inf; RTZ gives max finite; RDN gives max finite if positive, inf if negative; RUP gives inf if positive, max finite if negative; reserved gives max finite.
REQ-022 Inf is exp all ones with sig 0. Max finite is exp all ones minus 1 with sig all ones. sign_o = sign_i always.
REQ-023 Pipeline: stage 1 registers the decision and the N_SIG+1-bit sum; stage 2 registers the exponent adjust, the overflow pack and the flags. Latency is exactly 2 cycles with no stall.
REQ-024 s2_en = ~v2 | out_ready_i; s1_en = ~v1 | s2_en; in_ready_o = s1_en (combinational). Full throughput is 1 beat/cycle.
REQ-025 While out_valid_o=1 and out_ready_i=0, all output ports SHALL hold stable. Beats are never dropped, duplicated or reordered.
REQ-026 Accept and emit in the same cycle with both stages full SHALL advance both stages.

Reset
REQ-027 On rst_n_i low, v1, v2 and out_valid_o SHALL clear immediately. Every data and flag output SHALL read 0.
REQ-028 Beats in flight at reset SHALL be discarded. in_ready_o SHALL be 1 in the first cycle after release.

Configuration
REQ-029 With FROUND_FLAGS_EN defined, nx_o, of_o and rm_err_o SHALL be computed and pipelined as above.
REQ-030 Without FROUND_FLAGS_EN, the flag outputs SHALL be constant 0 and carry no flag registers. Overflow saturation (REQ-021) SHALL still apply.

Structure
REQ-031 The rounding-mode encodings (RNE..RMM, DYN) SHALL live in the shared package fpu_pkg. The stage-1 to stage-2 payload struct and the 3-bit mode type SHALL live there too.
REQ-032 The increment decision (REQ-016/017) SHALL be a combinational sub-module fround_decide. It SHALL be reusable by the integer rounder.

Verification (N_INT=32, N_EXP=8, N_SIG=23)
REQ-033 RNE tie, even: sig_i=0x8000_0080, exp_i=0x80 -> sig_o=0, exp_o=0x80, nx_o=1, two cycles later.
REQ-034 RNE tie, odd, carry: sig_i=0xFFFF_FF80, exp_i=0x10 -> sig_o=0, exp_o=0x11, nx_o=1.
REQ-035 Overflow: the same sig_i with exp_i=0xFE, RNE -> exp_o=0xFF, sig_o=0, of_o=1. Then exp_i=0xFF, RTZ -> exp_o=0xFE, sig_o=0x7FFFFF, of_o=1.
REQ-036 DYN: rm_i=111, frm_i=010, sign_i=1, sig_i=0x8000_0001 -> sig_o=1. With frm_i=101 -> sig_o=0, rm_err_o=1.
REQ-037 Backpressure: 3 back-to-back beats with out_ready_i low for 3 cycles -> in_ready_o low once both stages are full, outputs stable, all 3 beats delivered in order.
REQ-038 Reset asserted with 2 beats in flight -> out_valid_o=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, the 3-bit mode type and the
// fround stage-1 control payload. Flag fields exist only with FROUND_FLAGS_EN.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100,
      RM_DYN = 3'b111
   } rm_e;

   // Control half of the stage-1 register; the width-dependent sum and
   // exponent are held beside it in the rounder itself.
   typedef struct packed {
      logic sign;
      rm_e  mode;
`ifdef FROUND_FLAGS_EN
      logic nx;
      logic rm_err;
`endif
   } s1_ctrl_t;

   // A DYN selector takes the beat's frm; anything outside RNE..RMM after
   // that substitution is treated downstream as reserved.
   function automatic rm_e eff_mode(input logic [2:0] rm, input logic [2:0] frm);
      return (rm == 3'b111) ? rm_e'(frm) : rm_e'(rm);
   endfunction

endpackage

// File: rtl/fround_decide.sv
// Combinational round-increment decision from mode, sign and lsb/guard/sticky.
// Shared between the floating-point and integer rounders.
module fround_decide
   import fpu_pkg::*;
(
   input  rm_e  mode,
   input  logic sign,
   input  logic lsb,
   input  logic guard,
   input  logic sticky,
   output logic inc,
   output logic rm_err
);

   logic any_round;

   assign any_round = guard | sticky;

   always_comb begin
      inc    = 1'b0;
      rm_err = 1'b0;
      case (mode)
         RM_RNE:  inc = guard & (sticky | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & any_round;
         RM_RUP:  inc = ~sign & any_round;
         RM_RMM:  inc = guard;
         // Reserved encodings (and an unresolved DYN) truncate.
         default: rm_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/fround_pipe.sv
// Two-stage floating-point rounder with valid/ready flow control.
// Define FROUND_FLAGS_EN to compute and pipeline nx_o/of_o/rm_err_o.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never waits on ready, and a presented output holds until taken.
module fround_pipe
   import fpu_pkg::*;
#(
   parameter int N_INT = 32,
   parameter int N_EXP = 8,
   parameter int N_SIG = 23
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             sign_i,
   input  logic [N_INT-1:0] sig_i,
   input  logic [N_EXP-1:0] exp_i,
   input  logic [2:0]       rm_i,
   input  logic [2:0]       frm_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             sign_o,
   output logic [N_SIG-1:0] sig_o,
   output logic [N_EXP-1:0] exp_o,
   output logic             nx_o,
   output logic             of_o,
   output logic             rm_err_o
);

   localparam int RB_W = N_INT - N_SIG - 1;
   localparam logic [N_EXP-1:0] EXP_ONES = {N_EXP{1'b1}};
   localparam logic [N_EXP-1:0] EXP_MAXF = {{(N_EXP-1){1'b1}}, 1'b0};

   logic v1, v2;
   logic s1_en, s2_en, accept, advance;

   assign s2_en       = ~v2 | out_ready_i;
   assign s1_en       = ~v1 | s2_en;
   assign accept      = in_valid_i & s1_en;
   assign advance     = v1 & s2_en;
   assign in_ready_o  = s1_en;
   assign out_valid_o = v2;

   // Stage 1: mode resolution, increment decision and fraction sum
   rm_e            mode;
   logic           lsb, guard, sticky, inc, dec_err;
   logic [N_SIG:0] sum_d;

   assign mode   = eff_mode(rm_i, frm_i);
   assign lsb    = sig_i[RB_W];
   assign guard  = sig_i[RB_W-1];
   assign sticky = |sig_i[RB_W-2:0];

   fround_decide u_decide (
      .mode   (mode),
      .sign   (sign_i),
      .lsb    (lsb),
      .guard  (guard),
      .sticky (sticky),
      .inc    (inc),
      .rm_err (dec_err)
   );

   assign sum_d = {1'b0, sig_i[N_INT-2 -: N_SIG]} + {{N_SIG{1'b0}}, inc};

   s1_ctrl_t       ctrl1;
   logic [N_EXP-1:0] exp1;
   logic [N_SIG:0]   sum1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1    <= 1'b0;
         ctrl1 <= '0;
         exp1  <= '0;
         sum1  <= '0;
      end else begin
         if (s1_en) v1 <= in_valid_i;
         if (accept) begin
            ctrl1.sign <= sign_i;
            ctrl1.mode <= mode;
`ifdef FROUND_FLAGS_EN
            ctrl1.nx     <= |sig_i[RB_W-1:0];
            ctrl1.rm_err <= dec_err;
`endif
            exp1 <= exp_i;
            sum1 <= sum_d;
         end
      end
   end

   // Stage 2: exponent adjust and overflow saturation
   logic             carry, ovf, use_inf;
   logic [N_EXP-1:0] exp_inc, exp_pk;
   logic [N_SIG-1:0] sig_pk;

   always_comb begin
      carry   = sum1[N_SIG];
      exp_inc = exp1 + {{(N_EXP-1){1'b0}}, carry};
      // exp1 all ones wraps exp_inc on carry, so test the input exponent too
      ovf     = (exp1 == EXP_ONES) | (exp_inc == EXP_ONES);
      use_inf = 1'b0;
      case (ctrl1.mode)
         RM_RNE, RM_RMM: use_inf = 1'b1;
         RM_RDN:         use_inf = ctrl1.sign;
         RM_RUP:         use_inf = ~ctrl1.sign;
         default:        use_inf = 1'b0;
      endcase
      exp_pk = exp_inc;
      sig_pk = sum1[N_SIG-1:0];
      if (ovf) begin
         if (use_inf) begin
            exp_pk = EXP_ONES;
            sig_pk = '0;
         end else begin
            exp_pk = EXP_MAXF;
            sig_pk = '1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v2     <= 1'b0;
         sign_o <= 1'b0;
         sig_o  <= '0;
         exp_o  <= '0;
      end else begin
         if (s2_en) v2 <= v1;
         if (advance) begin
            sign_o <= ctrl1.sign;
            sig_o  <= sig_pk;
            exp_o  <= exp_pk;
         end
      end
   end

`ifdef FROUND_FLAGS_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         nx_o     <= 1'b0;
         of_o     <= 1'b0;
         rm_err_o <= 1'b0;
      end else if (advance) begin
         nx_o     <= ctrl1.nx | ovf;
         of_o     <= ovf;
         rm_err_o <= ctrl1.rm_err;
      end
   end

   logic unused_ok;
   assign unused_ok = sig_i[N_INT-1];
`else
   assign nx_o     = 1'b0;
   assign of_o     = 1'b0;
   assign rm_err_o = 1'b0;

   // Implied-one bit and the reserved-mode indication have no consumer here.
   logic unused_ok;
   assign unused_ok = sig_i[N_INT-1] ^ dec_err;
`endif

endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: vector table, latency, backpressure, reset-in-flight
// and randomized traffic checked against an arithmetic reference model.
module tb_fround_pipe;

  localparam int N_INT = 32;
  localparam int N_EXP = 8;
  localparam int N_SIG = 23;
  localparam int W     = 1 + N_SIG + N_EXP + 3;
`ifdef FROUND_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             sign_in, sign_out;
  logic [N_INT-1:0] sig_in;
  logic [N_EXP-1:0] exp_in, exp_out;
  logic [2:0]       rm, frm;
  logic [N_SIG-1:0] sig_out;
  logic             nx, of, rm_err;

  fround_pipe #(.N_INT(N_INT), .N_EXP(N_EXP), .N_SIG(N_SIG)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sign_i(sign_in), .sig_i(sig_in), .exp_i(exp_in), .rm_i(rm), .frm_i(frm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sign_o(sign_out), .sig_o(sig_out), .exp_o(exp_out),
    .nx_o(nx), .of_o(of), .rm_err_o(rm_err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] obs();
    return {sign_out, sig_out, exp_out, nx, of, rm_err};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (sign|sig|exp|nx|of|err)", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got %h want no beat", obs());
      end else begin
        check_vec("out_beat", obs(), exp_q.pop_front());
      end
    end
  end

  // reference model: rounding from the value of the discarded bits
  function automatic logic [W-1:0] model(input logic sign, input logic [31:0] sig,
                                         input logic [7:0] exp, input logic [2:0] rmv,
                                         input logic [2:0] frmv);
    int unsigned frac, rb, mode, total, rexp;
    bit inc, ovf, rsv, to_inf;
    logic [22:0] rs;
    logic [7:0]  re;
    frac = (sig >> 8) & 32'h7F_FFFF;
    rb   = sig & 32'hFF;
    mode = (rmv == 3'd7) ? frmv : rmv;
    rsv  = mode > 4;
    case (mode)
      0:       inc = (rb > 128) || (rb == 128 && frac % 2 == 1);
      2:       inc = sign && rb != 0;
      3:       inc = !sign && rb != 0;
      4:       inc = rb >= 128;
      default: inc = 1'b0;
    endcase
    total = frac + inc;
    rexp  = exp + (total >> 23);
    rs    = 23'(total % (1 << 23));
    re    = 8'(rexp);
    ovf   = (exp == 8'd255) || (rexp >= 255);
    if (ovf) begin
      to_inf = (mode == 0) || (mode == 4) || (mode == 2 && sign) || (mode == 3 && !sign);
      re = to_inf ? 8'd255 : 8'd254;
      rs = to_inf ? 23'd0 : 23'h7F_FFFF;
    end
    return {sign, rs, re, FLAGS & (rb != 0 || ovf), FLAGS & ovf, FLAGS & rsv};
  endfunction

  // driver tasks: called at posedge+1, return at posedge+1 after acceptance
  task automatic send(input logic s, input logic [31:0] sg, input logic [7:0] e,
                      input logic [2:0] r, input logic [2:0] f, input logic [W-1:0] req);
    bit done;
    done = 1'b0;
    sign_in = s; sig_in = sg; exp_in = e; rm = r; frm = f; in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(req);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles want 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // vector table
  typedef struct {
    logic        sign;
    logic [31:0] sig;
    logic [7:0]  exp;
    logic [2:0]  rm, frm;
    logic [22:0] e_sig;
    logic [7:0]  e_exp;
    logic        e_nx, e_of, e_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic s, logic [31:0] sg, logic [7:0] e, logic [2:0] r,
                              logic [2:0] f, logic [22:0] es, logic [7:0] ee,
                              logic enx, logic eof, logic eerr);
    vec_t v;
    v.sign = s; v.sig = sg; v.exp = e; v.rm = r; v.frm = f;
    v.e_sig = es; v.e_exp = ee; v.e_nx = enx; v.e_of = eof; v.e_err = eerr;
    return v;
  endfunction

  function automatic logic [W-1:0] vec_req(vec_t v);
    return {v.sign, v.e_sig, v.e_exp, FLAGS & v.e_nx, FLAGS & v.e_of, FLAGS & v.e_err};
  endfunction

  bit rand_done;

  initial begin
    vecs[0]  = mk(0, 32'h8000_0080, 8'h80, 3'b000, 3'b000, 23'h0,      8'h80, 1, 0, 0);
    vecs[1]  = mk(0, 32'hFFFF_FF80, 8'h10, 3'b000, 3'b000, 23'h0,      8'h11, 1, 0, 0);
    vecs[2]  = mk(0, 32'hFFFF_FF80, 8'hFE, 3'b000, 3'b000, 23'h0,      8'hFF, 1, 1, 0);
    vecs[3]  = mk(0, 32'hFFFF_FF80, 8'hFF, 3'b001, 3'b000, 23'h7FFFFF, 8'hFE, 1, 1, 0);
    vecs[4]  = mk(1, 32'h8000_0001, 8'h40, 3'b111, 3'b010, 23'h1,      8'h40, 1, 0, 0);
    vecs[5]  = mk(1, 32'h8000_0001, 8'h40, 3'b111, 3'b101, 23'h0,      8'h40, 1, 0, 1);
    vecs[6]  = mk(0, 32'hC000_0100, 8'h7F, 3'b000, 3'b000, 23'h400001, 8'h7F, 0, 0, 0);
    vecs[7]  = mk(0, 32'h8000_0080, 8'h80, 3'b100, 3'b000, 23'h1,      8'h80, 1, 0, 0);
    vecs[8]  = mk(1, 32'h8000_0001, 8'h20, 3'b011, 3'b000, 23'h0,      8'h20, 1, 0, 0);
    vecs[9]  = mk(0, 32'h8000_00FF, 8'h20, 3'b101, 3'b000, 23'h0,      8'h20, 1, 0, 1);
    vecs[10] = mk(1, 32'h8000_0000, 8'hFF, 3'b010, 3'b000, 23'h0,      8'hFF, 1, 1, 0);
    vecs[11] = mk(1, 32'h8000_0000, 8'hFF, 3'b011, 3'b000, 23'h7FFFFF, 8'hFE, 1, 1, 0);
    vecs[12] = mk(0, 32'h8000_01C1, 8'h05, 3'b000, 3'b000, 23'h2,      8'h05, 1, 0, 0);
    vecs[13] = mk(0, 32'h8000_0000, 8'hFF, 3'b110, 3'b000, 23'h7FFFFF, 8'hFE, 1, 1, 1);
    vecs[14] = mk(0, 32'hFFFF_FFFF, 8'hFE, 3'b010, 3'b000, 23'h7FFFFF, 8'hFE, 1, 0, 0);
    vecs[15] = mk(0, 32'hFFFF_FFFF, 8'hFE, 3'b011, 3'b000, 23'h0,      8'hFF, 1, 1, 0);

    // reset block
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; sig_in = '0; exp_in = '0; rm = '0; frm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_outputs", obs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // table-driven vectors, back to back
    for (int i = 0; i < 16; i++)
      send(vecs[i].sign, vecs[i].sig, vecs[i].exp, vecs[i].rm, vecs[i].frm, vec_req(vecs[i]));
    idle(1);
    drain();

    // latency: single beat into an empty pipe appears after two edges
    send(0, 32'h8000_0080, 8'h80, 3'b000, 3'b000, vec_req(vecs[0]));
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_cycle2_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // backpressure: three beats with the output stalled
    out_ready = 1'b0;
    fork
      begin
        send(0, 32'h8000_0080, 8'h80, 3'b000, 3'b000, vec_req(vecs[0]));
        send(0, 32'hFFFF_FF80, 8'h10, 3'b000, 3'b000, vec_req(vecs[1]));
        send(1, 32'h8000_0001, 8'h40, 3'b111, 3'b010, vec_req(vecs[4]));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          check_bit("bp_in_ready", in_ready, 1'b0);
          check_bit("bp_out_valid", out_valid, 1'b1);
          check_vec("bp_hold", obs(), exp_q[0]);
          if (c < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(0, 32'h8000_0080, 8'h80, 3'b000, 3'b000, vec_req(vecs[0]));
    send(0, 32'hC000_0100, 8'h7F, 3'b000, 3'b000, vec_req(vecs[6]));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("rst_inflight_valid", out_valid, 1'b0);
    check_vec("rst_inflight_out", obs(), '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("rst_release_ready", in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_bit("rst_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic        s;
          logic [31:0] sg;
          logic [7:0]  e;
          logic [2:0]  r, f;
          s  = 1'($urandom);
          sg = $urandom | 32'h8000_0000;
          case ($urandom_range(0, 3))
            0: sg[7:0] = 8'h80;
            1: sg[7:0] = 8'h00;
            default: ;
          endcase
          if ($urandom_range(0, 7) == 0) sg[30:8] = '1;
          e  = ($urandom_range(0, 7) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
          r  = 3'($urandom_range(0, 7));
          f  = 3'($urandom_range(0, 6));
          send(s, sg, e, r, f, model(s, sg, e, r, f));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
